// File: rtl/issue_queue_8e_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_8e_pkg
// Shared widths, the dispatched-op record and the writeback tag-match helper
// for the 8-entry issue queue and its entry sub-module.
// ---------------------------------------------------------------------------
package issue_queue_8e_pkg;

  localparam int RRF_SEL     = 6;
  localparam int TAG_W       = RRF_SEL;
  localparam int AGE_W       = RRF_SEL;
  localparam int PAYLOAD_W   = 32;
  localparam int NUM_WB      = 2;
  localparam int ISQ_ENTRIES = 8;
  localparam int ISQ_IDX_W   = 3;
  localparam int CNT_W       = ISQ_IDX_W + 1;

  // Everything dispatch hands to an entry when it is allocated.
  typedef struct packed {
    logic [TAG_W-1:0]     s1Tag;
    logic                 s1Rdy;
    logic [TAG_W-1:0]     s2Tag;
    logic                 s2Rdy;
    logic [PAYLOAD_W-1:0] payload;
  } disp_op_t;

  // True when any valid writeback port broadcasts the given tag.
  function automatic logic tag_hit(
    input logic [NUM_WB-1:0]       wbValid,
    input logic [NUM_WB*TAG_W-1:0] wbTag,
    input logic [TAG_W-1:0]        tag
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wbValid[p] && (wbTag[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/issue_queue_8e_if.sv
// ---------------------------------------------------------------------------
// issue_queue_8e_if
// Bundles dispatch, writeback broadcast, selector and issue signals.
//   slave  : the issue queue (consumes dispatch/wb/grant, drives req/age/issue)
//   master : the surrounding pipeline / selector driving the queue
// ---------------------------------------------------------------------------
interface issue_queue_8e_if;
  import issue_queue_8e_pkg::*;

  logic                          flush;
  logic                          disp_valid;
  logic                          disp_ready;
  logic [TAG_W-1:0]              disp_src1_tag;
  logic                          disp_src1_rdy;
  logic [TAG_W-1:0]              disp_src2_tag;
  logic                          disp_src2_rdy;
  logic [PAYLOAD_W-1:0]          disp_payload;
  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB*TAG_W-1:0]       wb_tag;
  logic                          issue_en;
  logic [ISQ_ENTRIES-1:0]        req;
  logic [ISQ_ENTRIES*AGE_W-1:0]  age;
  logic [ISQ_ENTRIES*ISQ_IDX_W-1:0] index;
  logic                          grant;
  logic [ISQ_IDX_W-1:0]          grant_index;
  logic                          issue_valid;
  logic [PAYLOAD_W-1:0]          issue_payload;

  modport slave (
    input  flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
           disp_src2_rdy, disp_payload, wb_valid, wb_tag, issue_en, grant,
           grant_index,
    output disp_ready, req, age, index, issue_valid, issue_payload
  );

  modport master (
    output flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
           disp_src2_rdy, disp_payload, wb_valid, wb_tag, issue_en, grant,
           grant_index,
    input  disp_ready, req, age, index, issue_valid, issue_payload
  );

endinterface

// File: rtl/issue_queue_8e_entry.sv
// ---------------------------------------------------------------------------
// issue_q_entry
// One reservation-station slot: operand tags with sticky ready bits woken by
// writeback broadcasts, a compacted age rank, the payload, and its request.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   i_flush             kill this entry
//   i_alloc, i_op       write a newly dispatched op
//   i_rankNew           rank assigned to the new op
//   i_wbValid, i_wbTag  writeback broadcast ports
//   i_issueFire         some entry issues this cycle
//   i_selected          this entry is the grant target
//   i_issuedRank        rank of the entry that issues
//   i_issueEn           execute stage accepts
//   o_valid, o_req, o_rank, o_payload  entry state towards the top level
// ---------------------------------------------------------------------------
module issue_q_entry
  import issue_queue_8e_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_alloc,
  input  disp_op_t              i_op,
  input  logic [ISQ_IDX_W-1:0]  i_rankNew,
  input  logic [NUM_WB-1:0]     i_wbValid,
  input  logic [NUM_WB*TAG_W-1:0] i_wbTag,
  input  logic                  i_issueFire,
  input  logic                  i_selected,
  input  logic [ISQ_IDX_W-1:0]  i_issuedRank,
  input  logic                  i_issueEn,
  output logic                  o_valid,
  output logic                  o_req,
  output logic [ISQ_IDX_W-1:0]  o_rank,
  output logic [PAYLOAD_W-1:0]  o_payload
);

  logic                 r_valid;
  logic [TAG_W-1:0]     r_s1Tag;
  logic                 r_s1Rdy;
  logic [TAG_W-1:0]     r_s2Tag;
  logic                 r_s2Rdy;
  logic [ISQ_IDX_W-1:0] r_rank;
  logic [PAYLOAD_W-1:0] r_payload;

  logic w_s1Hit, w_s2Hit, w_newS1Hit, w_newS2Hit;

  assign w_s1Hit    = tag_hit(i_wbValid, i_wbTag, r_s1Tag);
  assign w_s2Hit    = tag_hit(i_wbValid, i_wbTag, r_s2Tag);
  // Broadcasts in the dispatch cycle are captured so the op is not stranded.
  assign w_newS1Hit = tag_hit(i_wbValid, i_wbTag, i_op.s1Tag);
  assign w_newS2Hit = tag_hit(i_wbValid, i_wbTag, i_op.s2Tag);

  // Allocation only targets a free slot, so it never collides with issue.
  // Older-than-issued entries keep their rank; younger ones close the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_s1Tag   <= '0;
      r_s1Rdy   <= 1'b0;
      r_s2Tag   <= '0;
      r_s2Rdy   <= 1'b0;
      r_rank    <= '0;
      r_payload <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_alloc) begin
      r_valid   <= 1'b1;
      r_s1Tag   <= i_op.s1Tag;
      r_s1Rdy   <= i_op.s1Rdy | w_newS1Hit;
      r_s2Tag   <= i_op.s2Tag;
      r_s2Rdy   <= i_op.s2Rdy | w_newS2Hit;
      r_rank    <= i_rankNew;
      r_payload <= i_op.payload;
    end else if (r_valid) begin
      if (i_issueFire && i_selected) begin
        r_valid <= 1'b0;
      end else begin
        r_s1Rdy <= r_s1Rdy | w_s1Hit;
        r_s2Rdy <= r_s2Rdy | w_s2Hit;
        if (i_issueFire && (r_rank > i_issuedRank)) r_rank <= r_rank - 1'b1;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_req     = r_valid & r_s1Rdy & r_s2Rdy & i_issueEn;
  assign o_rank    = r_rank;
  assign o_payload = r_payload;

endmodule

// File: rtl/issue_queue_8e.sv
// ---------------------------------------------------------------------------
// issue_queue_8e
// 8-entry age-tracked issue queue feeding a 1-of-8 oldest-first selector.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   io_bus      issue_queue_8e_if.slave: dispatch, writeback broadcasts,
//               per-entry req/age/index, grant/grant_index, issue output
// ---------------------------------------------------------------------------
module issue_queue_8e
  import issue_queue_8e_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  issue_queue_8e_if.slave  io_bus
);

  logic [ISQ_ENTRIES-1:0] w_valid;
  logic [ISQ_ENTRIES-1:0] w_req;
  logic [ISQ_ENTRIES-1:0] w_alloc;
  logic [ISQ_IDX_W-1:0]   w_rank    [ISQ_ENTRIES];
  logic [PAYLOAD_W-1:0]   w_payload [ISQ_ENTRIES];

  logic [CNT_W-1:0]       r_count;
  logic                   r_issueValid;
  logic [PAYLOAD_W-1:0]   r_issuePayload;

  logic                   w_dispReady;
  logic                   w_dispatch;
  logic                   w_issueFire;
  logic [ISQ_IDX_W-1:0]   w_freeIdx;
  logic [ISQ_IDX_W-1:0]   w_rankNew;
  logic [ISQ_IDX_W-1:0]   w_issuedRank;
  disp_op_t               w_op;
  logic [ISQ_ENTRIES*AGE_W-1:0]     w_age;
  logic [ISQ_ENTRIES*ISQ_IDX_W-1:0] w_index;

  // Readiness comes from the registered count only, so an issue in the same
  // cycle cannot make room for that cycle's dispatch.
  assign w_dispReady = (r_count < CNT_W'(ISQ_ENTRIES));
  assign w_dispatch  = io_bus.disp_valid & w_dispReady & ~io_bus.flush;
  assign w_issueFire = io_bus.grant & io_bus.issue_en &
                       w_valid[io_bus.grant_index] & w_req[io_bus.grant_index];
  assign w_issuedRank = w_rank[io_bus.grant_index];
  // The issuing entry leaves the rank order in the same edge.
  assign w_rankNew   = r_count[ISQ_IDX_W-1:0] - ISQ_IDX_W'(w_issueFire);

  assign w_op.s1Tag   = io_bus.disp_src1_tag;
  assign w_op.s1Rdy   = io_bus.disp_src1_rdy;
  assign w_op.s2Tag   = io_bus.disp_src2_tag;
  assign w_op.s2Rdy   = io_bus.disp_src2_rdy;
  assign w_op.payload = io_bus.disp_payload;

  // Lowest-index free slot; scanning downward leaves the smallest match.
  always_comb begin
    w_freeIdx = '0;
    for (int i = ISQ_ENTRIES - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_freeIdx = ISQ_IDX_W'(i);
    end
  end

  assign w_alloc = w_dispatch ? (ISQ_ENTRIES'(1) << w_freeIdx) : '0;

  for (genvar g = 0; g < ISQ_ENTRIES; g++) begin : g_entry
    issue_q_entry u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (io_bus.flush),
      .i_alloc      (w_alloc[g]),
      .i_op         (w_op),
      .i_rankNew    (w_rankNew),
      .i_wbValid    (io_bus.wb_valid),
      .i_wbTag      (io_bus.wb_tag),
      .i_issueFire  (w_issueFire),
      .i_selected   (io_bus.grant_index == ISQ_IDX_W'(g)),
      .i_issuedRank (w_issuedRank),
      .i_issueEn    (io_bus.issue_en),
      .o_valid      (w_valid[g]),
      .o_req        (w_req[g]),
      .o_rank       (w_rank[g]),
      .o_payload    (w_payload[g])
    );
  end

  // Occupancy tracks dispatches in and issues out; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (io_bus.flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_dispatch) - CNT_W'(w_issueFire);
    end
  end

  // Issue register: payload holds between issues so execute sees a stable bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issueValid   <= 1'b0;
      r_issuePayload <= '0;
    end else if (io_bus.flush) begin
      r_issueValid <= 1'b0;
    end else if (w_issueFire) begin
      r_issueValid   <= 1'b1;
      r_issuePayload <= w_payload[io_bus.grant_index];
    end else begin
      r_issueValid <= 1'b0;
    end
  end

  // Ranks are zero-extended to the selector's age width; index is constant.
  always_comb begin
    w_age   = '0;
    w_index = '0;
    for (int i = 0; i < ISQ_ENTRIES; i++) begin
      w_age[i*AGE_W +: AGE_W]         = AGE_W'(w_rank[i]);
      w_index[i*ISQ_IDX_W +: ISQ_IDX_W] = ISQ_IDX_W'(i);
    end
  end

  assign io_bus.disp_ready    = w_dispReady;
  assign io_bus.req           = w_req;
  assign io_bus.age           = w_age;
  assign io_bus.index         = w_index;
  assign io_bus.issue_valid   = r_issueValid;
  assign io_bus.issue_payload = r_issuePayload;

endmodule
